// File: rtl/oc8051_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : oc8051_ifetch
//  Purpose  : Instruction-fetch initiator for the oc8051 core. Addresses the
//             program ROM, which returns a registered 3-byte window one cycle
//             later. Addresses outside the internal ROM are fetched one byte
//             at a time over a req/ack external bus. The instruction length
//             is decoded, and op1..op3 plus the length go to the decoder
//             under a valid/ready handshake.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             pc_load, pc_new          redirect request and target
//             rom_addr, rom_ea_int     ROM fetch address / internal flag
//             rom_data1..rom_data3     ROM window at rom_addr, +1, +2
//             ext_req, ext_addr        external byte request and address
//             ext_ack, ext_data        external byte response
//             op_valid, op_ready       decoder handshake
//             op1..op3, op_len, op_pc  instruction bytes, length, address
//  Revision : 1.0  initial release
// ============================================================================
module oc8051_ifetch #(
    parameter logic [15:0] RST_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    output logic [15:0] rom_addr,
    input  logic        rom_ea_int,
    input  logic [7:0]  rom_data1,
    input  logic [7:0]  rom_data2,
    input  logic [7:0]  rom_data3,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    input  logic        ext_ack,
    input  logic [7:0]  ext_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [7:0]  op3,
    output logic [1:0]  op_len,
    output logic [15:0] op_pc
);

    localparam logic [1:0] S_ADDR = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_EXT  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // Instruction length from the opcode byte.
    function automatic logic [1:0] f_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if (op[4:0] == 5'b00001) len = 2'd2;      // AJMP / ACALL
        case (op)
            8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
            8'h75, 8'h85, 8'h90, 8'hD5:
                len = 2'd3;
            8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42,
            8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62,
            8'h64, 8'h65, 8'h70, 8'h72, 8'h74, 8'h80, 8'h82, 8'h92,
            8'h94, 8'h95, 8'hA0, 8'hA2, 8'hB0, 8'hB2, 8'hC0, 8'hC2,
            8'hC5, 8'hD0, 8'hD2, 8'hE5, 8'hF5:
                len = 2'd2;
            default: ;
        endcase
        if (op >= 8'hB4 && op <= 8'hBF) len = 2'd3;
        if ((op >= 8'h76 && op <= 8'h7F) || (op >= 8'h86 && op <= 8'h8F) ||
            (op >= 8'hA6 && op <= 8'hAF) || (op >= 8'hD8 && op <= 8'hDF))
            len = 2'd2;
        return len;
    endfunction

    logic [1:0]  r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_rom_addr, w_rom_addr_nxt;
    logic        r_ext_req, w_ext_req_nxt;
    logic [15:0] r_ext_addr, w_ext_addr_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic        r_redir, w_redir_nxt;   // redirect arrived while a byte was outstanding
    logic [7:0]  r_op1, w_op1_nxt;
    logic [7:0]  r_op2, w_op2_nxt;
    logic [7:0]  r_op3, w_op3_nxt;
    logic [1:0]  r_op_len, w_op_len_nxt;
    logic [15:0] r_op_pc, w_op_pc_nxt;
    logic        r_op_valid, w_op_valid_nxt;

    logic [1:0]  w_win_len;
    logic [1:0]  w_ext_len;
    logic [1:0]  w_idx_inc;
    logic [1:0]  w_len_cur;
    logic        w_ext_hit;

    assign w_win_len = f_len(rom_data1);
    assign w_ext_len = f_len(ext_data);
    assign w_idx_inc = r_idx + 2'd1;
    // The first byte defines the length; later bytes use the stored length.
    assign w_len_cur = (r_idx == 2'd0) ? w_ext_len : r_op_len;
    assign w_ext_hit = r_ext_req && ext_ack;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_rom_addr_nxt = r_rom_addr;
        w_ext_req_nxt  = r_ext_req;
        w_ext_addr_nxt = r_ext_addr;
        w_idx_nxt      = r_idx;
        w_redir_nxt    = r_redir;
        w_op1_nxt      = r_op1;
        w_op2_nxt      = r_op2;
        w_op3_nxt      = r_op3;
        w_op_len_nxt   = r_op_len;
        w_op_pc_nxt    = r_op_pc;
        w_op_valid_nxt = r_op_valid;

        case (r_state)
            S_ADDR: begin
                if (rom_ea_int) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt    = S_EXT;
                    w_ext_req_nxt  = 1'b1;
                    w_ext_addr_nxt = r_pc;
                    w_idx_nxt      = 2'd0;
                end
            end
            S_WAIT: begin
                w_op1_nxt      = rom_data1;
                w_op_len_nxt   = w_win_len;
                w_op2_nxt      = (w_win_len >= 2'd2) ? rom_data2 : 8'h00;
                w_op3_nxt      = (w_win_len == 2'd3) ? rom_data3 : 8'h00;
                w_op_pc_nxt    = r_pc;
                w_op_valid_nxt = 1'b1;
                w_state_nxt    = S_HOLD;
            end
            S_EXT: begin
                if (w_ext_hit) begin
                    if (r_redir) begin
                        // Byte belongs to the abandoned fetch; drop it.
                        w_ext_req_nxt = 1'b0;
                        w_redir_nxt   = 1'b0;
                        w_state_nxt   = S_ADDR;
                    end else begin
                        case (r_idx)
                            2'd0: begin
                                w_op1_nxt    = ext_data;
                                w_op_len_nxt = w_ext_len;
                                w_op2_nxt    = 8'h00;
                                w_op3_nxt    = 8'h00;
                            end
                            2'd1:    w_op2_nxt = ext_data;
                            default: w_op3_nxt = ext_data;
                        endcase
                        if (w_idx_inc < w_len_cur) begin
                            w_idx_nxt      = w_idx_inc;
                            w_ext_addr_nxt = r_pc + {14'd0, w_idx_inc};
                        end else begin
                            w_ext_req_nxt  = 1'b0;
                            w_op_pc_nxt    = r_pc;
                            w_op_valid_nxt = 1'b1;
                            w_state_nxt    = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (op_ready) begin
                    w_op_valid_nxt = 1'b0;
                    w_pc_nxt       = r_pc + {14'd0, r_op_len};
                    w_rom_addr_nxt = r_pc + {14'd0, r_op_len};
                    w_state_nxt    = S_ADDR;
                end
            end
            default: w_state_nxt = S_ADDR;
        endcase

        // Redirect overrides everything decided above.
        if (pc_load) begin
            w_pc_nxt       = pc_new;
            w_rom_addr_nxt = pc_new;
            w_op_valid_nxt = 1'b0;
            if (r_state == S_EXT && !w_ext_hit) begin
                // The external bus cannot abort a request: keep it until ack.
                w_redir_nxt = 1'b1;
                w_state_nxt = S_EXT;
            end else begin
                w_ext_req_nxt = 1'b0;
                w_redir_nxt   = 1'b0;
                w_state_nxt   = S_ADDR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_ADDR;
            r_pc       <= RST_PC;
            r_rom_addr <= RST_PC;
            r_ext_req  <= 1'b0;
            r_ext_addr <= 16'h0000;
            r_idx      <= 2'd0;
            r_redir    <= 1'b0;
            r_op1      <= 8'h00;
            r_op2      <= 8'h00;
            r_op3      <= 8'h00;
            r_op_len   <= 2'd0;
            r_op_pc    <= 16'h0000;
            r_op_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_ext_req  <= w_ext_req_nxt;
            r_ext_addr <= w_ext_addr_nxt;
            r_idx      <= w_idx_nxt;
            r_redir    <= w_redir_nxt;
            r_op1      <= w_op1_nxt;
            r_op2      <= w_op2_nxt;
            r_op3      <= w_op3_nxt;
            r_op_len   <= w_op_len_nxt;
            r_op_pc    <= w_op_pc_nxt;
            r_op_valid <= w_op_valid_nxt;
        end
    end

    assign rom_addr = r_rom_addr;
    assign ext_req  = r_ext_req;
    assign ext_addr = r_ext_addr;
    assign op_valid = r_op_valid;
    assign op1      = r_op1;
    assign op2      = r_op2;
    assign op3      = r_op3;
    assign op_len   = r_op_len;
    assign op_pc    = r_op_pc;

endmodule
`default_nettype wire
